sdio_cmd: RTL and testbench
===========================

// Module: sdio_cmd
// PURPOSE
//  CMD-line engine; consumes tx_en/rx_en strobes from sdio_clk (sd_clk domain).
//  Serialises a 48-bit command: start, dir, index, arg, CRC7, end.
//  Optionally captures a 48/136-bit response with CRC7, index, end-bit and timeout checks,
//  then enforces the NCC gap before the next command.
// PARAMETERS
//  TIMEOUT  64  max rx_en strobes from end of command to response start bit (NCR); 1..255
//  NCC      8   tx_en strobes after completion before busy drops; 1..255
// PORTS
//  sd_clk      in   1    system clock (same as sdio_clk)
//  sd_rst      in   1    async reset, active-high
//  tx_en       in   1    1-cycle strobe, card clock about to fall: drive cmd_o
//  rx_en       in   1    1-cycle strobe, card clock about to rise: sample cmd_i
//  cmd_start   in   1    request pulse; accepted only when busy=0
//  cmd_index   in   6    command index, latched on accept
//  cmd_arg     in   32   argument, latched on accept
//  resp_type   in   2    00 none, 01 48-bit, 10 136-bit, 11 48-bit no CRC/index check (R3)
//  cmd_i       in   1    CMD pad input
//  cmd_o       out  1    CMD pad output
//  cmd_oe      out  1    CMD pad output enable
//  busy        out  1    high from accept until NCC gap complete
//  done        out  1    1-cycle pulse; result/flags valid
//  resp        out  128  48-bit resp: [31:0]=content bits 39:8; 136-bit: [127:1]=bits 127:1, [0]=0
//  resp_index  out  6    index field of 48-bit response (bits 45:40)
//  err_timeout out  1    no start bit within TIMEOUT
//  err_crc     out  1    CRC7 mismatch (types 01/10 only)
//  err_end     out  1    end bit sampled 0
//  err_index   out  1    type 01: resp_index != cmd_index
// BEHAVIOUR
//  Reset: all outputs 0 (cmd_o=1 is NOT required; cmd_o=0, cmd_oe=0), FSM=IDLE, counters 0.
//  Strobes: tx_en and rx_en never coincide; no strobe = no progress (pause/clock-off freeze FSM).
//  FSM IDLE->TX->(NCC | WAIT->RX->NCC)->IDLE.
//  IDLE: cmd_start=1 -> latch index/arg/type, busy=1 same edge, go TX. cmd_start when busy: ignored.
//  TX: each tx_en drives next bit MSB-first; first tx_en: cmd_oe=1, cmd_o=0 (start).
//   Then dir=1, index[5:0], arg[31:0], CRC7[6:0], end=1 (48 bits total).
//   CRC7: poly x^7+x^3+1, init 0, over first 40 bits. fb=crc[6]^bit; crc={crc[5:0],1'b0}^(fb?7'h09:0).
//   The tx_en after the end bit: cmd_oe=0, cmd_o=0; go NCC (type 00, done pulses) or WAIT.
//  WAIT: each rx_en increments wait counter; rx_en with cmd_i=0 -> start bit, bit count=1, go RX.
//   Counter reaching TIMEOUT without start: err_timeout=1, done pulse, go NCC.
//  RX: shift cmd_i on each rx_en; total 48 (types 01/11) or 136 (type 10) bits incl. start.
//   CRC over bits 47..8 (48-bit) or 127..8 (136-bit); compared with received bits 7:1.
//   Bit 0 is end bit. On last bit: set resp/resp_index/err flags, pulse done, go NCC.
//  Flags: cleared on accept, valid from done until next accept; several may be set together.
//  NCC: count NCC tx_en strobes, cmd_oe=0; then busy=0, IDLE.
//   A cmd_start that coincides with the busy-drop edge is ignored.
//  Bit counter 8-bit; no wrap possible (max 136).
//  sd_rst mid-operation: immediate abort; cmd_oe drops asynchronously; no done pulse.
// TESTING
//  CMD0 arg 0, type 00 -> 48 tx_en bits = 0x400000000095; done, then busy low after 8 tx_en.
//  CMD8 arg 0x1AA, type 01 -> tx 0x48000001AA87; card returns 0x08000001AA13
//   -> resp[31:0]=0x000001AA, resp_index=8, all err=0.
//  CMD8 with no card reply (cmd_i=1) -> err_timeout=1 after 64 rx_en, done pulse, others 0.
//  CMD8 reply CRC byte 0x15 -> err_crc=1. Same reply under type 11 -> err_crc=0, err_index=0.
//  CMD2 type 10, 136-bit R2 with valid CRC -> resp[127:1] match, err=0.
//   Bit-flip -> err_crc=1. End bit 0 -> err_end=1.
//  Hold tx_en low mid-TX for 100 cycles, then resume -> frame identical.
//   Assert sd_rst at bit 20 -> cmd_oe=0 at once, busy=0, no done.

Source files
------------

// File: rtl/sdio_cmd.sv
// SD/SDIO CMD-line engine: serialises a 48-bit command on tx_en strobes and
// optionally captures a 48/136-bit response on rx_en strobes, then holds busy for the NCC gap.
module sdio_cmd #(
  parameter int TIMEOUT = 64,
  parameter int NCC     = 8
) (
  input  logic         sd_clk,
  input  logic         sd_rst,
  input  logic         tx_en,
  input  logic         rx_en,
  input  logic         cmd_start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  input  logic         cmd_i,
  output logic         cmd_o,
  output logic         cmd_oe,
  output logic         busy,
  output logic         done,
  output logic [127:0] resp,
  output logic [5:0]   resp_index,
  output logic         err_timeout,
  output logic         err_crc,
  output logic         err_end,
  output logic         err_index
);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_NCC} state_t;

  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [7:0] NCC_LAST = 8'(NCC - 1);

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  state_t       state, state_nxt;
  logic [47:0]  tx_sr;
  logic [126:0] rx_sr;
  logic [127:0] rx_nxt;
  logic [7:0]   bit_cnt, wait_cnt, ncc_cnt;
  logic [6:0]   crc;
  logic [5:0]   idx_q;
  logic [1:0]   type_q;
  logic [7:0]   rx_last_cnt;
  logic         crc_in;
  logic         accept, tx_bit, tx_release, wait_tick, w_timeout;
  logic         rx_start, rx_bit, rx_last, ncc_tick, ncc_end;

  assign rx_nxt      = {rx_sr, cmd_i};
  assign rx_last_cnt = (type_q == 2'b10) ? 8'd135 : 8'd47;
  // 136-bit CRC skips the start/transmission/reserved header byte
  assign crc_in      = (type_q == 2'b10) ? (bit_cnt >= 8'd8 && bit_cnt < 8'd128)
                                         : (bit_cnt < 8'd40);

  always_ff @(posedge sd_clk or posedge sd_rst) begin
    if (sd_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    tx_bit     = 1'b0;
    tx_release = 1'b0;
    wait_tick  = 1'b0;
    w_timeout  = 1'b0;
    rx_start   = 1'b0;
    rx_bit     = 1'b0;
    rx_last    = 1'b0;
    ncc_tick   = 1'b0;
    ncc_end    = 1'b0;
    case (state)
      S_IDLE: if (cmd_start) begin
        accept    = 1'b1;
        state_nxt = S_TX;
      end
      S_TX: if (tx_en) begin
        if (bit_cnt == 8'd48) begin
          tx_release = 1'b1;
          state_nxt  = (type_q == 2'b00) ? S_NCC : S_WAIT;
        end else begin
          tx_bit = 1'b1;
        end
      end
      S_WAIT: if (rx_en) begin
        if (!cmd_i) begin
          rx_start  = 1'b1;
          state_nxt = S_RX;
        end else if (wait_cnt == TO_LAST) begin
          w_timeout = 1'b1;
          state_nxt = S_NCC;
        end else begin
          wait_tick = 1'b1;
        end
      end
      S_RX: if (rx_en) begin
        rx_bit = 1'b1;
        if (bit_cnt == rx_last_cnt) begin
          rx_last   = 1'b1;
          state_nxt = S_NCC;
        end
      end
      S_NCC: if (tx_en) begin
        if (ncc_cnt == NCC_LAST) begin
          ncc_end   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          ncc_tick = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sd_clk or posedge sd_rst) begin
    if (sd_rst) begin
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      ncc_cnt     <= '0;
      crc         <= '0;
      idx_q       <= '0;
      type_q      <= '0;
      cmd_o       <= 1'b0;
      cmd_oe      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      resp        <= '0;
      resp_index  <= '0;
      err_timeout <= 1'b0;
      err_crc     <= 1'b0;
      err_end     <= 1'b0;
      err_index   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        tx_sr       <= {2'b01, cmd_index, cmd_arg, crc7_40({2'b01, cmd_index, cmd_arg}), 1'b1};
        idx_q       <= cmd_index;
        type_q      <= resp_type;
        bit_cnt     <= '0;
        wait_cnt    <= '0;
        ncc_cnt     <= '0;
        busy        <= 1'b1;
        err_timeout <= 1'b0;
        err_crc     <= 1'b0;
        err_end     <= 1'b0;
        err_index   <= 1'b0;
      end
      if (tx_bit) begin
        cmd_oe  <= 1'b1;
        cmd_o   <= tx_sr[47];
        tx_sr   <= {tx_sr[46:0], 1'b0};
        bit_cnt <= bit_cnt + 8'd1;
      end
      if (tx_release) begin
        cmd_oe <= 1'b0;
        cmd_o  <= 1'b0;
        done   <= (type_q == 2'b00);
      end
      if (wait_tick) wait_cnt <= wait_cnt + 8'd1;
      if (w_timeout) begin
        err_timeout <= 1'b1;
        done        <= 1'b1;
      end
      // start bit is a 0 and leaves an init-0 CRC unchanged
      if (rx_start) begin
        bit_cnt <= 8'd1;
        crc     <= '0;
        rx_sr   <= '0;
      end
      if (rx_bit) begin
        rx_sr   <= rx_nxt[126:0];
        bit_cnt <= bit_cnt + 8'd1;
        if (crc_in) crc <= crc7_step(crc, cmd_i);
      end
      if (rx_last) begin
        done    <= 1'b1;
        err_end <= ~rx_nxt[0];
        err_crc <= (type_q == 2'b01 || type_q == 2'b10) && (crc != rx_nxt[7:1]);
        err_index <= (type_q == 2'b01) && (rx_nxt[45:40] != idx_q);
        if (type_q == 2'b10) begin
          resp       <= {rx_nxt[127:1], 1'b0};
          resp_index <= '0;
        end else begin
          resp       <= {96'b0, rx_nxt[39:8]};
          resp_index <= rx_nxt[45:40];
        end
      end
      if (ncc_tick) ncc_cnt <= ncc_cnt + 8'd1;
      if (ncc_end)  busy    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdio_cmd.sv
// Randomized bench for sdio_cmd: drives card-clock strobes, plays a card, and
// compares frames, responses and flags against a polynomial-division reference model.
module tb_sdio_cmd;
  localparam int TIMEOUT = 64;
  localparam int NCC     = 8;

  logic         sd_clk = 1'b0;
  logic         sd_rst = 1'b1;
  logic         tx_en = 1'b0, rx_en = 1'b0, cmd_start = 1'b0, cmd_i = 1'b1;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_arg = '0;
  logic [1:0]   resp_type = '0;
  logic         cmd_o, cmd_oe, busy, done;
  logic [127:0] resp;
  logic [5:0]   resp_index;
  logic         err_timeout, err_crc, err_end, err_index;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  sdio_cmd #(.TIMEOUT(TIMEOUT), .NCC(NCC)) dut (
    .sd_clk(sd_clk), .sd_rst(sd_rst), .tx_en(tx_en), .rx_en(rx_en),
    .cmd_start(cmd_start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .resp_type(resp_type), .cmd_i(cmd_i), .cmd_o(cmd_o), .cmd_oe(cmd_oe),
    .busy(busy), .done(done), .resp(resp), .resp_index(resp_index),
    .err_timeout(err_timeout), .err_crc(err_crc), .err_end(err_end),
    .err_index(err_index)
  );

  always #5 sd_clk = ~sd_clk;

  always @(posedge sd_clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of msg*x^7 divided by x^7+x^3+1 (0x89)
  function automatic logic [6:0] crc7_ref(input logic [119:0] msg, input int n);
    logic [126:0] r;
    r = {msg, 7'b0};
    for (int i = n + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] exp_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, arg};
    return {m, crc7_ref({80'b0, m}, 40), 1'b1};
  endfunction

  task automatic idle_gap();
    repeat ($urandom_range(1, 3)) @(negedge sd_clk);
  endtask

  task automatic pulse_tx(input logic st, output logic o, output logic oe);
    @(negedge sd_clk) tx_en = 1'b1; cmd_start = st;
    @(negedge sd_clk) tx_en = 1'b0; cmd_start = 1'b0;
    o = cmd_o; oe = cmd_oe;
    idle_gap();
  endtask

  task automatic pulse_rx(input logic b);
    @(negedge sd_clk) cmd_i = b; rx_en = 1'b1;
    @(negedge sd_clk) rx_en = 1'b0; cmd_i = 1'b1;
    idle_gap();
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ);
    @(negedge sd_clk);
    cmd_index = idx; cmd_arg = arg; resp_type = typ; cmd_start = 1'b1;
    @(negedge sd_clk) cmd_start = 1'b0;
    chk("busy_accept", 128'(busy), 128'(1));
    chk("flags_clear", 128'({err_timeout, err_crc, err_end, err_index}), 128'(0));
  endtask

  task automatic send_frame(input int pause_at, output logic [47:0] fr);
    logic o, oe, oe_all;
    oe_all = 1'b1;
    fr = '0;
    for (int i = 0; i < 48; i++) begin
      pulse_rx(1'b1);
      if (i == pause_at) repeat (100) @(negedge sd_clk);
      pulse_tx(1'b0, o, oe);
      fr = {fr[46:0], o};
      oe_all = oe_all & oe;
    end
    chk("tx_oe", 128'(oe_all), 128'(1));
  endtask

  task automatic ncc_phase(input int d0);
    logic o, oe;
    int n;
    n = 0;
    while (busy && n < 300) begin
      pulse_tx(n == NCC - 1, o, oe);
      n++;
    end
    chk("ncc_len", 128'(n), 128'(NCC));
    chk("ncc_busy", 128'(busy), 128'(0));
    chk("done_once", 128'(done_cnt - d0), 128'(1));
  endtask

  // mode: 0 good reply, 1 content bit flip, 2 end bit 0, 3 wrong index, 4 no reply
  task automatic txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                     input int mode, input logic [119:0] content, input int pause_at,
                     input logic [47:0] lit);
    logic [47:0]  fr;
    logic [135:0] rb;
    logic [127:0] er;
    logic [39:0]  m40;
    logic [5:0]   ridx;
    logic [3:0]   ef;
    logic         o, oe;
    int d0, n, k;
    issue(idx, arg, typ);
    send_frame(pause_at, fr);
    chk("frame_model", 128'(fr), 128'(exp_frame(idx, arg)));
    if (lit != 48'h0) chk("frame_literal", 128'(fr), 128'(lit));
    d0 = done_cnt;
    pulse_tx(1'b0, o, oe);
    chk("release_oe_o", 128'({oe, o}), 128'(0));
    if (typ == 2'b00) begin
      chk("done_type0", 128'(done_cnt - d0), 128'(1));
      ef = 4'b0000;
    end else if (mode == 4) begin
      k = 0;
      while (done_cnt == d0 && k < TIMEOUT + 8) begin
        pulse_rx(1'b1);
        k++;
      end
      chk("timeout_len", 128'(k), 128'(TIMEOUT));
      ef = 4'b1000;
    end else begin
      if (typ == 2'b10) begin
        rb = {8'h3f, content, crc7_ref(content, 120), 1'b1};
        n = 136;
      end else begin
        ridx = (mode == 3) ? (idx ^ 6'h01) : idx;
        m40  = {2'b00, ridx, content[31:0]};
        rb   = {88'b0, m40, crc7_ref({80'b0, m40}, 40), 1'b1};
        n = 48;
      end
      if (mode == 1) rb[8 + $urandom_range(0, 31)] ^= 1'b1;
      if (mode == 2) rb[0] = 1'b0;
      er = (n == 136) ? {rb[127:1], 1'b0} : {96'b0, rb[39:8]};
      ef = {1'b0, (typ != 2'b11) && (mode == 1), mode == 2, (typ == 2'b01) && (mode == 3)};
      repeat ($urandom_range(0, 10)) begin
        pulse_tx(1'b0, o, oe);
        pulse_rx(1'b1);
      end
      for (int i = n - 1; i >= 0; i--) pulse_rx(rb[i]);
      chk("done_resp", 128'(done_cnt - d0), 128'(1));
      chk("resp", resp, er);
      if (n == 48) chk("resp_index", 128'(resp_index), 128'(rb[45:40]));
    end
    chk("flags", 128'({err_timeout, err_crc, err_end, err_index}), 128'(ef));
    ncc_phase(d0);
  endtask

  function automatic logic [119:0] rnd120();
    return {$urandom(), $urandom(), $urandom(), 24'($urandom())};
  endfunction

  initial begin
    logic o, oe;
    int d0;
    logic [1:0] typ;
    repeat (3) @(negedge sd_clk);
    chk("rst_ctrl", 128'({cmd_o, cmd_oe, busy, done, err_timeout, err_crc, err_end, err_index}), 128'(0));
    chk("rst_resp", resp, 128'(0));
    chk("rst_index", 128'(resp_index), 128'(0));
    sd_rst = 1'b0;
    repeat (2) @(negedge sd_clk);

    txn(6'd0, 32'h0, 2'b00, 0, 120'h0, -1, 48'h400000000095);
    txn(6'd8, 32'h1AA, 2'b01, 0, 120'h1AA, -1, 48'h48000001AA87);
    chk("cmd8_resp", resp, 128'h1AA);
    txn(6'd8, 32'h1AA, 2'b01, 4, 120'h0, -1, 48'h48000001AA87);
    txn(6'd8, 32'h1AA, 2'b01, 1, 120'h1AA, -1, 48'h0);
    txn(6'd8, 32'h1AA, 2'b11, 1, 120'h1AA, -1, 48'h0);
    txn(6'd2, 32'h0, 2'b10, 0, rnd120(), -1, 48'h0);
    txn(6'd2, 32'h0, 2'b10, 1, rnd120(), -1, 48'h0);
    txn(6'd2, 32'h0, 2'b10, 2, rnd120(), -1, 48'h0);
    txn(6'd17, 32'h0, 2'b01, 3, {88'b0, $urandom()}, -1, 48'h0);
    txn(6'($urandom()), $urandom(), 2'b01, 0, {88'b0, $urandom()}, 20, 48'h0);

    // start request while busy must not restart the frame
    issue(6'd5, 32'hDEADBEEF, 2'b00);
    cmd_index = 6'd9; cmd_arg = 32'h12345678; cmd_start = 1'b1;
    @(negedge sd_clk) cmd_start = 1'b0;
    begin
      logic [47:0] fr;
      send_frame(-1, fr);
      chk("busy_ignore", 128'(fr), 128'(exp_frame(6'd5, 32'hDEADBEEF)));
    end
    d0 = done_cnt;
    pulse_tx(1'b0, o, oe);
    ncc_phase(d0);

    for (int r = 0; r < 8; r++) begin
      typ = 2'($urandom_range(0, 3));
      txn(6'($urandom()), $urandom(), typ, (typ == 2'b00) ? 0 : int'($urandom_range(0, 4)),
          rnd120(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 47)) : -1, 48'h0);
    end

    // reset in the middle of a command
    issue(6'd0, 32'h0, 2'b00);
    for (int i = 0; i < 20; i++) pulse_tx(1'b0, o, oe);
    chk("oe_before_rst", 128'(cmd_oe), 128'(1));
    d0 = done_cnt;
    #2 sd_rst = 1'b1;
    #1 chk("rst_async_oe", 128'(cmd_oe), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    @(negedge sd_clk) sd_rst = 1'b0;
    repeat (4) @(negedge sd_clk);
    chk("rst_no_done", 128'(done_cnt - d0), 128'(0));
    txn(6'd0, 32'h0, 2'b00, 0, 120'h0, -1, 48'h400000000095);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
